// File: rtl/sig_bucket_table.sv
// sig_bucket_table: chained hash-bucket store for minhash signatures with in-order match walk
module sig_bucket_table #(
    parameter int S           = 4,
    parameter int BUCKET_BITS = 8,
    parameter int ENTRIES     = 1024
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            WFlag,
    input  logic [31:0]     wmemW_i,
    input  logic [31:0]     WGID,
    input  logic [S*32-1:0] WmemVal,
    input  logic [1:0]      RFlag,
    input  logic [31:0]     RmemVal,
    output logic [31:0]     RmemW_i,
    output logic [31:0]     RGID,
    output logic            rd_valid,
    output logic            rd_miss,
    output logic            busy,
    output logic            overflow
);
    localparam int PTR_W = $clog2(ENTRIES);
    localparam int BKTS  = 1 << BUCKET_BITS;
    localparam int IDX_W = $clog2(S + 1);
    typedef logic [PTR_W:0] ptr_t;
    // Pointers carry one extra bit; NIL is the value with only that bit set (ENTRIES is a power of two).
    localparam ptr_t NIL = ptr_t'(ENTRIES);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(S - 1);
    typedef enum logic [1:0] {IDLE, INS, WALK} state_t;
    logic [31:0]      key_mem  [ENTRIES];
    logic [31:0]      w_mem    [ENTRIES];
    logic [31:0]      g_mem    [ENTRIES];
    ptr_t             next_mem [ENTRIES];
    logic [PTR_W-1:0] head_q   [BKTS];
    logic [PTR_W-1:0] tail_q   [BKTS];
    logic [BKTS-1:0]  bkt_valid_q;
    state_t           state_q;
    logic [S*32-1:0]  wsig_q;
    logic [31:0]      ww_q, wg_q, key_q, rw_q, rg_q;
    logic [IDX_W-1:0] idx_q;
    ptr_t             free_q, ptr_q, cur_q;
    logic             busy_q, ovf_q, rd_valid_q, rd_miss_q;
    logic [31:0]      ins_key;
    logic [BUCKET_BITS-1:0] ib, rb;
    logic [PTR_W-1:0] fidx, pidx;
    logic             full, hit;
    ptr_t             ptr_d;

    assign RmemW_i  = rw_q;
    assign RGID     = rg_q;
    assign rd_valid = rd_valid_q;
    assign rd_miss  = rd_miss_q;
    assign busy     = busy_q;
    assign overflow = ovf_q;

    // Current insert candidate (low word of the shifting strobe), walk entry compare and successor.
    always_comb begin
        ins_key = wsig_q[31:0];
        ib      = ins_key[BUCKET_BITS-1:0];
        rb      = RmemVal[BUCKET_BITS-1:0];
        fidx    = free_q[PTR_W-1:0];
        pidx    = ptr_q[PTR_W-1:0];
        full    = free_q[PTR_W];
        hit     = !ptr_q[PTR_W] && (key_mem[pidx] == key_q);
        ptr_d   = next_mem[pidx];
    end

    // Entry pool: write the new entry at the free slot and link it behind the bucket tail.
    always_ff @(posedge clk) begin
        if (state_q == INS && !full) begin
            key_mem[fidx]  <= ins_key;
            w_mem[fidx]    <= ww_q;
            g_mem[fidx]    <= wg_q;
            next_mem[fidx] <= NIL;
            if (bkt_valid_q[ib])
                next_mem[tail_q[ib]] <= free_q;
        end
    end

    // Control FSM: accepts one command when idle, then inserts S sigs or walks one chain entry per cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            bkt_valid_q <= '0;
            for (int i = 0; i < BKTS; i++) begin
                head_q[i] <= '0;
                tail_q[i] <= '0;
            end
            wsig_q      <= '0;
            ww_q        <= '0;
            wg_q        <= '0;
            key_q       <= '0;
            idx_q       <= '0;
            free_q      <= '0;
            ptr_q       <= NIL;
            cur_q       <= NIL;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_miss_q   <= 1'b0;
            rw_q        <= '0;
            rg_q        <= '0;
        end else begin
            rd_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (WFlag) begin
                        wsig_q  <= WmemVal;
                        ww_q    <= wmemW_i;
                        wg_q    <= WGID;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= INS;
                    end else if (RFlag == 2'b10) begin
                        key_q   <= RmemVal;
                        ptr_q   <= bkt_valid_q[rb] ? {1'b0, head_q[rb]} : NIL;
                        busy_q  <= 1'b1;
                        state_q <= WALK;
                    end else if (RFlag == 2'b01) begin
                        ptr_q   <= cur_q;
                        busy_q  <= 1'b1;
                        state_q <= WALK;
                    end
                end
                INS: begin
                    if (full) begin
                        ovf_q <= 1'b1;
                    end else begin
                        if (!bkt_valid_q[ib])
                            head_q[ib] <= fidx;
                        tail_q[ib]      <= fidx;
                        bkt_valid_q[ib] <= 1'b1;
                        free_q          <= free_q + ptr_t'(1);
                    end
                    wsig_q <= wsig_q >> 32;
                    idx_q  <= idx_q + IDX_W'(1);
                    if (idx_q == LAST) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                WALK: begin
                    if (ptr_q[PTR_W] || hit) begin
                        rd_valid_q <= 1'b1;
                        rd_miss_q  <= !hit;
                        cur_q      <= hit ? ptr_d : NIL;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                        if (hit) begin
                            rw_q <= w_mem[pidx];
                            rg_q <= g_mem[pidx];
                        end
                    end else begin
                        ptr_q <= ptr_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sig_bucket_table.sv
// tb_sig_bucket_table: table-driven lookups against a latency-aware scoreboard, plus reset/overflow sequences
module tb_sig_bucket_table;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         WFlag = 1'b0;
    logic [31:0]  wmemW_i = '0, WGID = '0, RmemVal = '0;
    logic [127:0] WmemVal = '0;
    logic [1:0]   RFlag = '0;
    logic [31:0]  RmemW_i, RGID, s_RmemW_i, s_RGID;
    logic         rd_valid, rd_miss, busy, overflow;
    logic         s_rd_valid, s_rd_miss, s_busy, s_overflow;

    sig_bucket_table u_dut (
        .clk(clk), .reset(reset), .WFlag(WFlag), .wmemW_i(wmemW_i), .WGID(WGID),
        .WmemVal(WmemVal), .RFlag(RFlag), .RmemVal(RmemVal), .RmemW_i(RmemW_i), .RGID(RGID),
        .rd_valid(rd_valid), .rd_miss(rd_miss), .busy(busy), .overflow(overflow)
    );

    sig_bucket_table #(.ENTRIES(8)) u_small (
        .clk(clk), .reset(reset), .WFlag(WFlag), .wmemW_i(wmemW_i), .WGID(WGID),
        .WmemVal(WmemVal), .RFlag(RFlag), .RmemVal(RmemVal), .RmemW_i(s_RmemW_i), .RGID(s_RGID),
        .rd_valid(s_rd_valid), .rd_miss(s_rd_miss), .busy(s_busy), .overflow(s_overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          miss;
        logic [31:0] w;
        logic [31:0] g;
        int          due;
    } exp_t;

    typedef struct {
        int           op;
        logic [1:0]   f;
        logic [127:0] d;
        logic [31:0]  w;
        logic [31:0]  g;
        bit           miss;
        int           lat;
    } vec_t;

    exp_t        q[$];
    vec_t        tv[$];
    int          checks = 0, failures = 0, seen = 0, v0;
    logic [31:0] lw = '0, lg = '0, snap_sw = '0;
    logic        snap_sv = 1'b0, snap_sm = 1'b0;

    function automatic vec_t V(int op, logic [1:0] f, logic [127:0] d, logic [31:0] w, logic [31:0] g, bit miss, int lat);
        vec_t v;
        v.op = op; v.f = f; v.d = d; v.w = w; v.g = g; v.miss = miss; v.lat = lat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        WFlag = 1'b0;
        RFlag = 2'b00;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_miss", rd_miss, 0);
        chk("rst_RmemW_i", RmemW_i, 0);
        chk("rst_RGID", RGID, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_small_overflow", s_overflow, 0);
        q.delete();
        lw = '0;
        lg = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wr(input logic [127:0] sigs, input logic [31:0] w, input logic [31:0] g, input logic [1:0] rf);
        int n = 0;
        @(posedge clk);
        #1;
        WmemVal = sigs; wmemW_i = w; WGID = g; WFlag = 1'b1; RFlag = rf; RmemVal = 32'hAB;
        @(posedge clk);
        #1;
        WFlag = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 1) RFlag = 2'b00;
            if (!busy) break;
            n++;
        end
        chk("busy_len", n, 4);
    endtask

    task automatic rd(input logic [1:0] f, input logic [31:0] key, input bit miss, input logic [31:0] w, input logic [31:0] g, input int lat);
        exp_t e;
        @(posedge clk);
        #1;
        RFlag = f;
        RmemVal = key;
        if (!miss) begin
            lw = w;
            lg = g;
        end
        e.miss = miss; e.w = lw; e.g = lg; e.due = cyc + lat;
        q.push_back(e);
        @(posedge clk);
        #1;
        RFlag = 2'b00;
        for (int i = 0; i < 20 && q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL rd_timeout: got no rd_valid for key %0h expected one by cycle %0d", key, e.due);
            q.delete();
        end
    endtask

    initial begin
        fork
            forever begin
                exp_t e;
                @(negedge clk);
                if (rd_valid === 1'b1) begin
                    seen++;
                    snap_sv = s_rd_valid;
                    snap_sm = s_rd_miss;
                    snap_sw = s_RmemW_i;
                    if (q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_rd_valid: got rd_valid=1 at cycle %0d expected none", cyc);
                    end else begin
                        e = q.pop_front();
                        chk("rd_miss", rd_miss, e.miss);
                        chk("RmemW_i", RmemW_i, e.w);
                        chk("RGID", RGID, e.g);
                        chk("latency_cycle", cyc, e.due);
                    end
                end
            end
        join_none

        // op 0 reset, 1 write strobe, 2 lookup (d[31:0] = key)
        tv.push_back(V(0, 2'b00, 0, 0, 0, 0, 0));
        tv.push_back(V(2, 2'b01, 0, 0, 0, 1, 2));
        tv.push_back(V(2, 2'b10, 128'h1234, 0, 0, 1, 2));
        tv.push_back(V(1, 2'b00, {32'h40, 32'h30, 32'h20, 32'h10}, 5, 1, 0, 0));
        tv.push_back(V(2, 2'b10, 128'h30, 5, 1, 0, 2));
        tv.push_back(V(2, 2'b01, 0, 0, 0, 1, 2));
        tv.push_back(V(2, 2'b10, 128'h10, 5, 1, 0, 2));
        tv.push_back(V(0, 2'b00, 0, 0, 0, 0, 0));
        tv.push_back(V(1, 2'b00, {32'h203, 32'h202, 32'h201, 32'h110}, 1, 0, 0, 0));
        tv.push_back(V(1, 2'b00, {32'h206, 32'h205, 32'h204, 32'h10}, 2, 1, 0, 0));
        tv.push_back(V(2, 2'b10, 128'h10, 2, 1, 0, 3));
        tv.push_back(V(2, 2'b10, 128'h110, 1, 0, 0, 2));
        tv.push_back(V(2, 2'b01, 0, 0, 0, 1, 3));
        tv.push_back(V(2, 2'b10, 128'h310, 0, 0, 1, 4));
        tv.push_back(V(0, 2'b00, 0, 0, 0, 0, 0));
        tv.push_back(V(1, 2'b00, {32'hC3, 32'hC2, 32'hC1, 32'hAB}, 10, 0, 0, 0));
        tv.push_back(V(1, 2'b00, {32'hC3, 32'hC2, 32'hC1, 32'hAB}, 11, 1, 0, 0));
        tv.push_back(V(1, 2'b00, {32'hC3, 32'hC2, 32'hC1, 32'hAB}, 12, 2, 0, 0));
        tv.push_back(V(2, 2'b10, 128'hAB, 10, 0, 0, 2));
        tv.push_back(V(2, 2'b01, 0, 11, 1, 0, 2));
        tv.push_back(V(2, 2'b01, 0, 12, 2, 0, 2));
        tv.push_back(V(2, 2'b01, 0, 0, 0, 1, 2));
        tv.push_back(V(2, 2'b10, 128'hC2, 10, 0, 0, 2));

        for (int i = 0; i < tv.size(); i++) begin
            case (tv[i].op)
                0: do_reset();
                1: wr(tv[i].d, tv[i].w, tv[i].g, 2'b00);
                default: rd(tv[i].f, tv[i].d[31:0], tv[i].miss, tv[i].w, tv[i].g, tv[i].lat);
            endcase
        end
        chk("idle_after_reads", busy, 0);

        // RFlag=11 is ignored; a read alongside a write is dropped, as is a read while busy
        v0 = seen;
        @(posedge clk);
        #1;
        RFlag = 2'b11;
        RmemVal = 32'hAB;
        @(posedge clk);
        #1;
        RFlag = 2'b00;
        repeat (4) @(negedge clk);
        chk("rflag11_ignored", seen, v0);
        chk("rflag11_not_busy", busy, 0);
        v0 = seen;
        wr({32'hD3, 32'hD2, 32'hD1, 32'hD0}, 32'h20, 9, 2'b10);
        repeat (4) @(negedge clk);
        chk("simul_read_dropped", seen, v0);
        rd(2'b10, 32'hD0, 0, 32'h20, 9, 2);
        rd(2'b01, 32'h0, 1, 0, 0, 2);

        // reset in the middle of an insert
        @(posedge clk);
        #1;
        WmemVal = {32'hE4, 32'hE3, 32'hE2, 32'hE1}; wmemW_i = 32'h33; WGID = 3; WFlag = 1'b1;
        @(posedge clk);
        #1;
        WFlag = 1'b0;
        @(negedge clk);
        chk("ins_busy", busy, 1);
        do_reset();
        rd(2'b10, 32'hE1, 1, 0, 0, 2);
        rd(2'b10, 32'hAB, 1, 0, 0, 2);

        // reset in the middle of a chain walk
        wr({32'h307, 32'h207, 32'h107, 32'h7}, 7, 7, 2'b00);
        rd(2'b10, 32'h307, 0, 7, 7, 5);
        @(posedge clk);
        #1;
        RFlag = 2'b10;
        RmemVal = 32'h307;
        @(posedge clk);
        #1;
        RFlag = 2'b00;
        @(negedge clk);
        chk("walk_busy", busy, 1);
        v0 = seen;
        do_reset();
        repeat (6) @(negedge clk);
        chk("walk_aborted", seen, v0);
        rd(2'b10, 32'h7, 1, 0, 0, 2);

        // pool exhaustion on the 8-entry instance
        do_reset();
        wr({32'h54, 32'h53, 32'h52, 32'h51}, 1, 5, 2'b00);
        wr({32'h58, 32'h57, 32'h56, 32'h55}, 2, 5, 2'b00);
        chk("small_not_full_yet", s_overflow, 0);
        wr({32'h5C, 32'h5B, 32'h5A, 32'h59}, 3, 5, 2'b00);
        chk("small_overflow", s_overflow, 1);
        chk("main_no_overflow", overflow, 0);
        rd(2'b10, 32'h5A, 0, 3, 5, 2);
        chk("small_dropped_valid", snap_sv, 1);
        chk("small_dropped_miss", snap_sm, 1);
        rd(2'b10, 32'h58, 0, 2, 5, 2);
        chk("small_last_valid", snap_sv, 1);
        chk("small_last_miss", snap_sm, 0);
        chk("small_last_w", snap_sw, 2);
        chk("small_overflow_sticky", s_overflow, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
